// File: rtl/rr_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// rr_handshake_arbiter
//
// Round-robin arbiter that shares one downstream valid/ready channel between N
// upstream valid/ready requesters. The winning beat is captured in a
// forward-registered output stage: valid/data/last/grant are flopped, and
// ready_o is combinational. This gives full throughput, because a held beat can
// drain and be replaced by a new one on the same edge.
//
// Optional feature (compile-time macro ARB_PKT_LOCK_EN):
//   When the macro is defined, accepting a beat with last_i[k]=0 locks the
//   grant to requester k until k delivers a beat with last_i[k]=1. While the
//   lock is held, other requesters see ready_o=0, even if k is idle. The
//   round-robin pointer only advances when a packet completes.
//   When the macro is undefined, arbitration is per beat and last_i is only
//   carried through to last_o.
//
// Parameters:
//   WIDTH  data width per requester, in bits
//   N      number of requesters (2..16)
//
// Ports:
//   clk      clock; all state updates on posedge
//   rst      synchronous reset, active-high
//   valid_i  [N]        per-requester valid
//   ready_o  [N]        per-requester ready, at most one bit high
//   data_i   [N*WIDTH]  requester k at data_i[k*WIDTH +: WIDTH]
//   last_i   [N]        per-requester end-of-packet flag
//   valid_o             downstream valid (registered)
//   ready_i             downstream ready
//   data_o   [WIDTH]    downstream data (registered)
//   last_o              registered last flag of the held beat
//   grant_o  [N]        registered one-hot source of the held beat, 0 when idle
// -----------------------------------------------------------------------------
module rr_handshake_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       valid_i,
  output logic [N-1:0]       ready_o,
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [N-1:0]       last_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               last_o,
  output logic [N-1:0]       grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  logic [PW-1:0]    ptr_q;
  logic             free;
  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    win_inc;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

`ifdef ARB_PKT_LOCK_EN
  logic             lock_q;
  logic [PW-1:0]    lock_idx_q;
`endif

  // The output slot can take a new beat when it is empty, or when it is being
  // drained on this very cycle.
  assign free = ~valid_o | ready_i;

  // Winner search: the first requesting index, starting at ptr_q and wrapping
  // modulo N. A held packet lock overrides the search.
  always_comb begin : winner_search
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    // NOTE: every signal written here gets a default first. That way no path
    // leaves it unassigned, and no latch is inferred.
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef ARB_PKT_LOCK_EN
    if (lock_q) begin
      found = valid_i[lock_idx_q];
      win   = lock_idx_q;
    end
`endif
  end

  assign win_inc  = (win == PW'(N - 1)) ? '0 : win + PW'(1);
  assign sel_data = data_i[int'(win) * WIDTH +: WIDTH];

  // Ready is withheld during reset. A beat handed over in that cycle would be
  // thrown away by the reset, so the requester keeps it instead.
  assign accept  = found & free & ~rst;
  assign ready_o = accept ? (ONE_HOT0 << win) : '0;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values, whatever order the processes are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      grant_o <= '0;
      ptr_q   <= '0;
`ifdef ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= sel_data;
      last_o  <= last_i[win];
      grant_o <= ONE_HOT0 << win;
`ifdef ARB_PKT_LOCK_EN
      if (last_i[win]) begin
        lock_q <= 1'b0;
        ptr_q  <= win_inc;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= win;
      end
`else
      ptr_q <= win_inc;
`endif
    end else if (ready_i) begin
      // The held beat drained and nothing replaced it. data_o and last_o
      // keep their last values.
      valid_o <= 1'b0;
      grant_o <= '0;
    end
  end

endmodule
